hazard_ctrl_p: RTL and testbench

//  Parametrised hazard/forwarding controller for the 5-stage (IF/ID/EX/MEM/WB) pipeline.

---
 rtl/hazard_ctrl_p_pkg.sv | 13 +
 rtl/hazard_ctrl_p_if.sv | 33 +++
 rtl/hazard_ctrl_p_cnt.sv | 22 ++
 rtl/hazard_ctrl_p.sv | 103 ++++++++++
 tb/tb_hazard_ctrl_p.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_p_pkg.sv
// Shared pipeline constants for the hazard/forwarding controller: forward selects,
// PC source encodings and the default register-address width.
package hazard_ctrl_p_pkg;

  localparam int RA_W_DFLT = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [1:0] PC_SEQ  = 2'b00;

endpackage

// File: rtl/hazard_ctrl_p_if.sv
// Bundle between the pipeline stages (master) and the hazard controller (slave):
// stage register fields in, stall/flush/forward controls out.
interface hazard_ctrl_p_if
  import hazard_ctrl_p_pkg::*;
#(
  parameter int RA_W = RA_W_DFLT
);
  logic [RA_W-1:0] rs_id, rt_id, wreg_exe, wreg_mem, wreg_wb;
  logic            use_rs_id, use_rt_id, branch_id, md_use_id;
  logic [1:0]      pc_src_id;
  logic            reg_write_exe, mem_to_reg_exe, md_start_exe;
  logic            reg_write_mem, mem_to_reg_mem, reg_write_wb;

  logic            stall_if, stall_id, flush_exe, flush_id, stall_mem;
  logic [1:0]      fwd_a_exe, fwd_b_exe;
  logic            fwd_a_id, fwd_b_id;

  modport master (
    output rs_id, rt_id, use_rs_id, use_rt_id, branch_id, pc_src_id, md_use_id,
           wreg_exe, reg_write_exe, mem_to_reg_exe, md_start_exe,
           wreg_mem, reg_write_mem, mem_to_reg_mem, wreg_wb, reg_write_wb,
    input  stall_if, stall_id, flush_exe, flush_id, stall_mem,
           fwd_a_exe, fwd_b_exe, fwd_a_id, fwd_b_id
  );

  modport slave (
    input  rs_id, rt_id, use_rs_id, use_rt_id, branch_id, pc_src_id, md_use_id,
           wreg_exe, reg_write_exe, mem_to_reg_exe, md_start_exe,
           wreg_mem, reg_write_mem, mem_to_reg_mem, wreg_wb, reg_write_wb,
    output stall_if, stall_id, flush_exe, flush_id, stall_mem,
           fwd_a_exe, fwd_b_exe, fwd_a_id, fwd_b_id
  );
endinterface

// File: rtl/hazard_ctrl_p_cnt.sv
// Loadable down-counter that stops at zero; used for the data-memory latency
// timer and the mul/div busy timer.
module hz_down_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         nz
);

  assign nz = |cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     cnt <= '0;
    else if (load)  cnt <= load_val;
    else if (nz)    cnt <= cnt - W'(1);
  end

endmodule

// File: rtl/hazard_ctrl_p.sv
// Hazard/forwarding controller for the 5-stage pipeline: load-use, ID branch operand,
// mul/div busy and multi-cycle load interlocks plus EX/ID forward selects.
module hazard_ctrl_p
  import hazard_ctrl_p_pkg::*;
#(
  parameter int RA_W       = RA_W_DFLT,
  parameter int LOAD_LAT   = 1,
  parameter int MD_LAT     = 4,
  parameter int DELAY_SLOT = 1
) (
  input  logic           clock,
  input  logic           reset,
  hazard_ctrl_p_if.slave bus
);

  localparam int LAT_W = $clog2(LOAD_LAT + 1);
  localparam int MD_W  = $clog2(MD_LAT + 1);

  function automatic logic hit(input logic [RA_W-1:0] r, input logic [RA_W-1:0] w,
                               input logic we);
    return we && (r == w) && (r != '0);
  endfunction

  logic [RA_W-1:0]  rs_ex, rt_ex;
  logic             use_rs_ex, use_rt_ex;
  logic [LAT_W-1:0] lat_cnt;
  logic [MD_W-1:0]  md_cnt;
  logic             lat_nz, md_nz, lat_entry, md_busy;
  logic             lu_hz, br_hz, md_hz, stall_mem_i, id_stall;
  logic             mem_a, mem_b, wb_a, wb_b;

  // Counters hold cycles remaining including the current one; the final count of 1
  // is the cycle the result is available, so it no longer stalls.
  assign lat_entry   = (LOAD_LAT > 1) && bus.mem_to_reg_mem && !lat_nz;
  assign stall_mem_i = reset && (lat_entry || (lat_nz && lat_cnt != LAT_W'(1)));
  assign md_busy     = md_nz && md_cnt != MD_W'(1);

  hz_down_counter #(.W(LAT_W)) u_lat_cnt (
    .clock(clock), .reset(reset), .load(lat_entry),
    .load_val(LAT_W'(LOAD_LAT - 1)), .cnt(lat_cnt), .nz(lat_nz)
  );

  hz_down_counter #(.W(MD_W)) u_md_cnt (
    .clock(clock), .reset(reset), .load(bus.md_start_exe),
    .load_val(MD_W'(MD_LAT)), .cnt(md_cnt), .nz(md_nz)
  );

  assign lu_hz = (bus.use_rs_id && hit(bus.rs_id, bus.wreg_exe, bus.mem_to_reg_exe)) ||
                 (bus.use_rt_id && hit(bus.rt_id, bus.wreg_exe, bus.mem_to_reg_exe));

  // A branch compares in ID, so any EX producer or a load still in MEM must drain first.
  assign br_hz = bus.branch_id &&
                 ((bus.use_rs_id && hit(bus.rs_id, bus.wreg_exe, bus.reg_write_exe))  ||
                  (bus.use_rt_id && hit(bus.rt_id, bus.wreg_exe, bus.reg_write_exe))  ||
                  (bus.use_rs_id && hit(bus.rs_id, bus.wreg_mem, bus.mem_to_reg_mem)) ||
                  (bus.use_rt_id && hit(bus.rt_id, bus.wreg_mem, bus.mem_to_reg_mem)));

  assign md_hz    = bus.md_use_id && md_busy;
  assign id_stall = reset && !stall_mem_i && (lu_hz || br_hz || md_hz);

  assign bus.stall_mem = stall_mem_i;
  assign bus.stall_if  = id_stall;
  assign bus.stall_id  = id_stall;
  assign bus.flush_exe = id_stall;
  assign bus.flush_id  = reset && (DELAY_SLOT == 0) && (bus.pc_src_id != PC_SEQ) &&
                         !id_stall && !stall_mem_i;

  assign bus.fwd_a_id = reset && bus.branch_id && bus.use_rs_id && !bus.mem_to_reg_mem &&
                        hit(bus.rs_id, bus.wreg_mem, bus.reg_write_mem);
  assign bus.fwd_b_id = reset && bus.branch_id && bus.use_rt_id && !bus.mem_to_reg_mem &&
                        hit(bus.rt_id, bus.wreg_mem, bus.reg_write_mem);

  // A load in MEM has no ALU result to forward; the interlock guarantees it is not needed.
  assign mem_a = use_rs_ex && !bus.mem_to_reg_mem && hit(rs_ex, bus.wreg_mem, bus.reg_write_mem);
  assign mem_b = use_rt_ex && !bus.mem_to_reg_mem && hit(rt_ex, bus.wreg_mem, bus.reg_write_mem);
  assign wb_a  = use_rs_ex && hit(rs_ex, bus.wreg_wb, bus.reg_write_wb);
  assign wb_b  = use_rt_ex && hit(rt_ex, bus.wreg_wb, bus.reg_write_wb);

  assign bus.fwd_a_exe = mem_a ? FWD_MEM : (wb_a ? FWD_WB : FWD_REG);
  assign bus.fwd_b_exe = mem_b ? FWD_MEM : (wb_b ? FWD_WB : FWD_REG);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs_ex     <= '0;
      rt_ex     <= '0;
      use_rs_ex <= 1'b0;
      use_rt_ex <= 1'b0;
    end else if (!stall_mem_i) begin
      if (id_stall) begin
        rs_ex     <= '0;
        rt_ex     <= '0;
        use_rs_ex <= 1'b0;
        use_rt_ex <= 1'b0;
      end else begin
        rs_ex     <= bus.rs_id;
        rt_ex     <= bus.rt_id;
        use_rs_ex <= bus.use_rs_id;
        use_rt_ex <= bus.use_rt_id;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Directed bench for hazard_ctrl_p: instance a (LOAD_LAT=1, delay slot) and
// instance b (LOAD_LAT=3, no delay slot), hand-computed expected controls.
module tb_hazard_ctrl_p;
  import hazard_ctrl_p_pkg::*;

  logic clock;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_ctrl_p_if ifa ();
  hazard_ctrl_p_if ifb ();

  hazard_ctrl_p #(.LOAD_LAT(1), .MD_LAT(4), .DELAY_SLOT(1)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa)
  );
  hazard_ctrl_p #(.LOAD_LAT(3), .MD_LAT(4), .DELAY_SLOT(0)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {stall_if, stall_id, flush_exe, flush_id, stall_mem, fwd_a_exe, fwd_b_exe, fwd_a_id, fwd_b_id}
  function automatic logic [10:0] ex(input bit st, input bit fi, input bit sm,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input bit fai, input bit fbi);
    return {st, st, st, fi, sm, fa, fb, fai, fbi};
  endfunction

  function automatic logic [10:0] obs_a();
    return {ifa.stall_if, ifa.stall_id, ifa.flush_exe, ifa.flush_id, ifa.stall_mem,
            ifa.fwd_a_exe, ifa.fwd_b_exe, ifa.fwd_a_id, ifa.fwd_b_id};
  endfunction

  function automatic logic [10:0] obs_b();
    return {ifb.stall_if, ifb.stall_id, ifb.flush_exe, ifb.flush_id, ifb.stall_mem,
            ifb.fwd_a_exe, ifb.fwd_b_exe, ifb.fwd_a_id, ifb.fwd_b_id};
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic idle_a();
    ifa.rs_id = '0; ifa.rt_id = '0; ifa.use_rs_id = 0; ifa.use_rt_id = 0;
    ifa.branch_id = 0; ifa.pc_src_id = 2'b00; ifa.md_use_id = 0;
    ifa.wreg_exe = '0; ifa.reg_write_exe = 0; ifa.mem_to_reg_exe = 0; ifa.md_start_exe = 0;
    ifa.wreg_mem = '0; ifa.reg_write_mem = 0; ifa.mem_to_reg_mem = 0;
    ifa.wreg_wb = '0; ifa.reg_write_wb = 0;
  endtask

  task automatic idle_b();
    ifb.rs_id = '0; ifb.rt_id = '0; ifb.use_rs_id = 0; ifb.use_rt_id = 0;
    ifb.branch_id = 0; ifb.pc_src_id = 2'b00; ifb.md_use_id = 0;
    ifb.wreg_exe = '0; ifb.reg_write_exe = 0; ifb.mem_to_reg_exe = 0; ifb.md_start_exe = 0;
    ifb.wreg_mem = '0; ifb.reg_write_mem = 0; ifb.mem_to_reg_mem = 0;
    ifb.wreg_wb = '0; ifb.reg_write_wb = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle_a();
    idle_b();
    // hazards presented while in reset must not reach the outputs
    ifa.wreg_exe = 5'd2; ifa.reg_write_exe = 1; ifa.mem_to_reg_exe = 1;
    ifa.rs_id = 5'd2; ifa.use_rs_id = 1; ifa.md_use_id = 1;
    ifb.pc_src_id = 2'b01;
    #2;
    chk("reset_a", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));
    chk("reset_b", obs_b(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));
    #10;
    reset = 1'b1;
    idle_a();
    idle_b();
    #1;
    chk("post_reset_a", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));
    chk("post_reset_b", obs_b(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));

    // load-use: lw $2 in EX, add $2,$5 in ID
    tick(); idle_a();
    ifa.wreg_exe = 5'd2; ifa.reg_write_exe = 1; ifa.mem_to_reg_exe = 1;
    ifa.rs_id = 5'd2; ifa.use_rs_id = 1; ifa.rt_id = 5'd5; ifa.use_rt_id = 1;
    #1 chk("lu_stall", obs_a(), ex(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); idle_a();
    ifa.wreg_mem = 5'd2; ifa.reg_write_mem = 1; ifa.mem_to_reg_mem = 1;
    ifa.rs_id = 5'd2; ifa.use_rs_id = 1; ifa.rt_id = 5'd5; ifa.use_rt_id = 1;
    #1 chk("lu_bubble", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); idle_a();
    ifa.wreg_wb = 5'd2; ifa.reg_write_wb = 1;
    #1 chk("lu_fwd_wb", obs_a(), ex(0, 0, 0, 2'b01, 2'b00, 0, 0));

    // EX forwarding: EX reads rs=$3, rt=$0
    tick(); idle_a();
    ifa.rs_id = 5'd3; ifa.use_rs_id = 1; ifa.rt_id = 5'd0; ifa.use_rt_id = 1;
    #1 chk("fwd_setup", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); idle_a();
    ifa.wreg_mem = 5'd3; ifa.reg_write_mem = 1; ifa.wreg_wb = 5'd3; ifa.reg_write_wb = 1;
    #1 chk("fwd_mem_over_wb", obs_a(), ex(0, 0, 0, 2'b10, 2'b00, 0, 0));
    ifa.wreg_mem = 5'd0; ifa.wreg_wb = 5'd0;
    #1 chk("fwd_r0", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));
    ifa.wreg_mem = 5'd7; ifa.wreg_wb = 5'd3;
    #1 chk("fwd_wb_only", obs_a(), ex(0, 0, 0, 2'b01, 2'b00, 0, 0));
    ifa.wreg_mem = 5'd3; ifa.mem_to_reg_mem = 1;
    #1 chk("fwd_load_in_mem", obs_a(), ex(0, 0, 0, 2'b01, 2'b00, 0, 0));
    ifa.mem_to_reg_mem = 0; ifa.reg_write_mem = 0;
    #1 chk("fwd_mem_no_we", obs_a(), ex(0, 0, 0, 2'b01, 2'b00, 0, 0));

    // beq $4,$0 in ID behind lw $4
    tick(); idle_a();
    ifa.branch_id = 1; ifa.rs_id = 5'd4; ifa.use_rs_id = 1; ifa.use_rt_id = 1;
    ifa.wreg_exe = 5'd4; ifa.reg_write_exe = 1; ifa.mem_to_reg_exe = 1;
    #1 chk("br_lw_ex", obs_a(), ex(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); idle_a();
    ifa.branch_id = 1; ifa.rs_id = 5'd4; ifa.use_rs_id = 1; ifa.use_rt_id = 1;
    ifa.wreg_mem = 5'd4; ifa.reg_write_mem = 1; ifa.mem_to_reg_mem = 1;
    #1 chk("br_lw_mem", obs_a(), ex(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); idle_a();
    ifa.branch_id = 1; ifa.rs_id = 5'd4; ifa.use_rs_id = 1; ifa.use_rt_id = 1;
    ifa.wreg_wb = 5'd4; ifa.reg_write_wb = 1;
    #1 chk("br_release", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));

    // beq $4 behind addi $4: one stall, then forward from MEM
    tick(); idle_a();
    ifa.branch_id = 1; ifa.rs_id = 5'd4; ifa.use_rs_id = 1; ifa.use_rt_id = 1;
    ifa.wreg_exe = 5'd4; ifa.reg_write_exe = 1;
    #1 chk("br_alu_ex", obs_a(), ex(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); idle_a();
    ifa.branch_id = 1; ifa.rs_id = 5'd4; ifa.use_rs_id = 1; ifa.use_rt_id = 1;
    ifa.wreg_mem = 5'd4; ifa.reg_write_mem = 1;
    #1 chk("br_fwd_id_a", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 1, 0));
    ifa.rs_id = 5'd9; ifa.rt_id = 5'd4;
    #1 chk("br_fwd_id_b", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 1));
    ifa.pc_src_id = 2'b01;
    #1 chk("ds1_no_flush", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 1));

    // mul/div busy, MD_LAT=4: mflo right behind the start stalls 3 cycles
    tick(); idle_a();
    ifa.md_start_exe = 1;
    #1 chk("md_start", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); idle_a(); ifa.md_use_id = 1;
    #1 chk("md_stall1", obs_a(), ex(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick();
    #1 chk("md_stall2", obs_a(), ex(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick();
    #1 chk("md_stall3", obs_a(), ex(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick();
    #1 chk("md_release", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));

    // reset in the second busy cycle clears the interlock for good
    tick(); idle_a(); ifa.md_start_exe = 1;
    tick(); idle_a(); ifa.md_use_id = 1;
    #1 chk("md2_stall1", obs_a(), ex(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick();
    reset = 1'b0;
    #1 chk("md_in_reset", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));
    reset = 1'b1;
    #1 chk("md_after_reset", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));
    tick();
    #1 chk("md_after_reset2", obs_a(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));

    // LOAD_LAT=3: lw in MEM holds 2 cycles; ID load-use and taken branch wait behind it
    tick(); idle_b();
    ifb.wreg_mem = 5'd7; ifb.reg_write_mem = 1; ifb.mem_to_reg_mem = 1;
    ifb.wreg_exe = 5'd8; ifb.reg_write_exe = 1; ifb.mem_to_reg_exe = 1;
    ifb.rs_id = 5'd8; ifb.use_rs_id = 1; ifb.pc_src_id = 2'b01;
    #1 chk("ll_entry", obs_b(), ex(0, 0, 1, 2'b00, 2'b00, 0, 0));
    tick();
    #1 chk("ll_hold", obs_b(), ex(0, 0, 1, 2'b00, 2'b00, 0, 0));
    tick();
    #1 chk("ll_release_lu", obs_b(), ex(1, 0, 0, 2'b00, 2'b00, 0, 0));

    // DELAY_SLOT=0: taken branch flushes IF/ID unless ID is stalled
    tick(); idle_b(); ifb.pc_src_id = 2'b01;
    #1 chk("ds0_flush", obs_b(), ex(0, 1, 0, 2'b00, 2'b00, 0, 0));
    ifb.wreg_exe = 5'd8; ifb.reg_write_exe = 1; ifb.mem_to_reg_exe = 1;
    ifb.rs_id = 5'd8; ifb.use_rs_id = 1;
    #1 chk("ds0_suppressed", obs_b(), ex(1, 0, 0, 2'b00, 2'b00, 0, 0));
    tick(); idle_b();
    #1 chk("ds0_seq", obs_b(), ex(0, 0, 0, 2'b00, 2'b00, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
